// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_access_unit_pkg
// Brief  : Shared definitions for the load/store stage. Holds the data width,
//          the mem_op encodings, the FSM state codes and small op classifiers.
// Ports  : none (package)
// Rev    : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

  localparam int XLEN = 64;
  localparam int OP_W = 4;

  // mem_op encodings; 12..15 are treated as MEM_NONE
  localparam logic [3:0] MEM_NONE = 4'd0;
  localparam logic [3:0] MEM_LB   = 4'd1;
  localparam logic [3:0] MEM_LH   = 4'd2;
  localparam logic [3:0] MEM_LW   = 4'd3;
  localparam logic [3:0] MEM_LD   = 4'd4;
  localparam logic [3:0] MEM_LBU  = 4'd5;
  localparam logic [3:0] MEM_LHU  = 4'd6;
  localparam logic [3:0] MEM_LWU  = 4'd7;
  localparam logic [3:0] MEM_SB   = 4'd8;
  localparam logic [3:0] MEM_SH   = 4'd9;
  localparam logic [3:0] MEM_SW   = 4'd10;
  localparam logic [3:0] MEM_SD   = 4'd11;

  // FSM state codes
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= MEM_LB) && (op <= MEM_LWU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= MEM_SB) && (op <= MEM_SD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_align.sv
`default_nettype none
// ============================================================================
// Module : mem_align
// Brief  : Combinational byte-lane logic for the load/store stage.
//          Checks natural alignment, builds store strobes/data and extracts
//          and extends load data from a 64-bit bus word.
// Ports  : i_op         mem_op encoding
//          i_addr       byte offset within the doubleword (addr[2:0])
//          i_store_data rs2 value for stores
//          i_rdata      doubleword returned by the bus
//          o_wmask      byte strobes (0 for non-stores)
//          o_wdata      store data shifted into its byte lane
//          o_load_data  aligned and extended load result (0 for non-loads)
//          o_misalign   access is not naturally aligned
// Rev    : 1.0 - initial release
// ============================================================================
module mem_align
  import mem_access_unit_pkg::*;
(
  input  logic [3:0]      i_op,
  input  logic [2:0]      i_addr,
  input  logic [XLEN-1:0] i_store_data,
  input  logic [XLEN-1:0] i_rdata,
  output logic [7:0]      o_wmask,
  output logic [XLEN-1:0] o_wdata,
  output logic [XLEN-1:0] o_load_data,
  output logic            o_misalign
);

  logic [5:0]      w_shamt;
  logic [XLEN-1:0] w_lane;

  assign w_shamt = {i_addr, 3'b000};
  assign w_lane  = i_rdata >> w_shamt;
  assign o_wdata = i_store_data << w_shamt;

  always_comb begin
    o_wmask     = 8'h00;
    o_load_data = '0;
    o_misalign  = 1'b0;
    case (i_op)
      MEM_LB:  o_load_data = {{56{w_lane[7]}}, w_lane[7:0]};
      MEM_LBU: o_load_data = {56'd0, w_lane[7:0]};
      MEM_LH: begin
        o_misalign  = i_addr[0];
        o_load_data = {{48{w_lane[15]}}, w_lane[15:0]};
      end
      MEM_LHU: begin
        o_misalign  = i_addr[0];
        o_load_data = {48'd0, w_lane[15:0]};
      end
      MEM_LW: begin
        o_misalign  = |i_addr[1:0];
        o_load_data = {{32{w_lane[31]}}, w_lane[31:0]};
      end
      MEM_LWU: begin
        o_misalign  = |i_addr[1:0];
        o_load_data = {32'd0, w_lane[31:0]};
      end
      MEM_LD: begin
        o_misalign  = |i_addr;
        o_load_data = i_rdata;
      end
      MEM_SB: o_wmask = 8'h01 << i_addr;
      MEM_SH: begin
        o_misalign = i_addr[0];
        o_wmask    = 8'h03 << i_addr;
      end
      MEM_SW: begin
        o_misalign = |i_addr[1:0];
        o_wmask    = 8'h0F << i_addr;
      end
      MEM_SD: begin
        o_misalign = |i_addr;
        o_wmask    = 8'hFF;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module : mem_access_unit
// Brief  : Load/store stage. Accepts one instruction from exe, performs at
//          most one valid/ready bus transaction, and hands the (extended)
//          result to write-back through a valid/ready handshake.
// Ports  : clk, rst (async, active-low)
//          in_valid/in_ready, mem_op, alu_result, store_data, rd_in, wen_in
//          bus_req_valid/bus_req_ready, bus_addr, bus_wen, bus_wdata, bus_wmask
//          bus_rsp_valid, bus_rsp_rdata
//          out_valid/out_ready, out_data, out_rd, out_wen, misalign
// Rev    : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] mem_op,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] store_data,
  input  logic [4:0]      rd_in,
  input  logic            wen_in,
  output logic            bus_req_valid,
  input  logic            bus_req_ready,
  output logic [XLEN-1:0] bus_addr,
  output logic            bus_wen,
  output logic [XLEN-1:0] bus_wdata,
  output logic [7:0]      bus_wmask,
  input  logic            bus_rsp_valid,
  input  logic [XLEN-1:0] bus_rsp_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic            misalign
);

  logic [1:0]      r_state;
  logic [3:0]      r_op;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_sdata;
  logic [XLEN-1:0] r_data;
  logic [4:0]      r_rd;
  logic            r_wen;
  logic            r_misalign;

  logic            w_idle;
  logic            w_req;
  logic [3:0]      w_in_op;
  logic [3:0]      w_al_op;
  logic [2:0]      w_al_addr;
  logic [XLEN-1:0] w_al_sdata;
  logic [7:0]      w_wmask;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_load_data;
  logic            w_misalign;

  assign w_idle  = (r_state == S_IDLE);
  assign w_req   = (r_state == S_REQ);
  // Reserved encodings collapse to NONE at the input
  assign w_in_op = (mem_op > MEM_SD) ? MEM_NONE : mem_op;

  // The aligner sees the live inputs in IDLE (so the accept cycle can decide
  // misalignment) and the captured instruction in every other state.
  assign w_al_op    = w_idle ? w_in_op          : r_op;
  assign w_al_addr  = w_idle ? alu_result[2:0]  : r_addr[2:0];
  assign w_al_sdata = w_idle ? store_data       : r_sdata;

  mem_align u_align (
    .i_op         (w_al_op),
    .i_addr       (w_al_addr),
    .i_store_data (w_al_sdata),
    .i_rdata      (bus_rsp_rdata),
    .o_wmask      (w_wmask),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data),
    .o_misalign   (w_misalign)
  );

  assign in_ready      = w_idle;
  assign bus_req_valid = w_req;
  assign bus_addr      = {r_addr[XLEN-1:3], 3'b000};
  assign bus_wen       = w_req & is_store(r_op);
  assign bus_wmask     = w_req ? w_wmask : 8'h00;
  assign bus_wdata     = w_req ? w_wdata : '0;
  assign out_valid     = (r_state == S_DONE);
  assign out_data      = r_data;
  assign out_rd        = r_rd;
  assign out_wen       = r_wen;
  assign misalign      = r_misalign;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_op       <= MEM_NONE;
      r_addr     <= '0;
      r_sdata    <= '0;
      r_data     <= '0;
      r_rd       <= '0;
      r_wen      <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op       <= w_in_op;
            r_addr     <= alu_result;
            r_sdata    <= store_data;
            r_rd       <= rd_in;
            r_misalign <= w_misalign;
            r_wen      <= wen_in & ~is_store(w_in_op) & ~w_misalign;
            // Stores and misaligned ops report 0; loads overwrite in WAIT
            r_data     <= (w_in_op == MEM_NONE) ? alu_result : '0;
            r_state    <= ((w_in_op == MEM_NONE) || w_misalign) ? S_DONE : S_REQ;
          end
        end
        S_REQ: begin
          if (bus_req_ready) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus_rsp_valid) begin
            if (is_load(r_op)) r_data <= w_load_data;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_access_unit
// Brief  : Directed self-checking bench for mem_access_unit.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  mem_op = '0;
  logic [63:0] alu_result = '0;
  logic [63:0] store_data = '0;
  logic [4:0]  rd_in = '0;
  logic        wen_in = 1'b0;
  logic        bus_req_valid;
  logic        bus_req_ready = 1'b0;
  logic [63:0] bus_addr;
  logic        bus_wen;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wmask;
  logic        bus_rsp_valid = 1'b0;
  logic [63:0] bus_rsp_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        misalign;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .mem_op        (mem_op),
    .alu_result    (alu_result),
    .store_data    (store_data),
    .rd_in         (rd_in),
    .wen_in        (wen_in),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_addr      (bus_addr),
    .bus_wen       (bus_wen),
    .bus_wdata     (bus_wdata),
    .bus_wmask     (bus_wmask),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rsp_rdata (bus_rsp_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_rd        (out_rd),
    .out_wen       (out_wen),
    .misalign      (misalign)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [3:0] op, input logic [63:0] addr,
                        input logic [63:0] sd, input logic [4:0] rd, input logic wen);
    mem_op     = op;
    alu_result = addr;
    store_data = sd;
    rd_in      = rd;
    wen_in     = wen;
    in_valid   = 1'b1;
    tick();
    in_valid   = 1'b0;
  endtask

  // Grant the request immediately, answer one cycle later; ends in DONE
  task automatic bus_xfer(input logic [63:0] rdata);
    bus_req_ready = 1'b1;
    tick();
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b1;
    bus_rsp_rdata = rdata;
    tick();
    bus_rsp_valid = 1'b0;
  endtask

  initial begin
    // ---------------- reset state
    tick();
    tick();
    chk("rst_in_ready",  in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_req_valid", bus_req_valid, 0);
    chk("rst_out_data",  out_data, 0);
    rst = 1'b1;
    tick();

    // ---------------- 1: reset during REQ
    accept(4'd4, 64'h0000_0000_8000_0010, 64'd0, 5'd1, 1'b1);
    tick();
    chk("t1_req_before_rst", bus_req_valid, 1);
    rst = 1'b0;
    #1;
    chk("t1_req_drop_async", bus_req_valid, 0);
    tick();
    rst = 1'b1;
    chk("t1_req_after", bus_req_valid, 0);
    chk("t1_in_ready", in_ready, 1);
    tick();
    bus_rsp_valid = 1'b1;
    bus_rsp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    bus_rsp_valid = 1'b0;
    chk("t1_no_out_valid_a", out_valid, 0);
    tick();
    chk("t1_no_out_valid_b", out_valid, 0);

    // ---------------- 2: LB / LBU lane extraction
    accept(4'd1, 64'h0000_0000_8000_0003, 64'd0, 5'd7, 1'b1);
    chk("t2_lb_req", bus_req_valid, 1);
    chk("t2_lb_addr", bus_addr, 64'h0000_0000_8000_0000);
    chk("t2_lb_wmask", {56'd0, bus_wmask}, 0);
    bus_xfer(64'h0000_0000_8000_0000);
    chk("t2_lb_valid", out_valid, 1);
    chk("t2_lb_data", out_data, 64'hFFFF_FFFF_FFFF_FF80);
    chk("t2_lb_wen", out_wen, 1);
    chk("t2_lb_rd", {59'd0, out_rd}, 7);
    tick();
    accept(4'd5, 64'h0000_0000_8000_0003, 64'd0, 5'd7, 1'b1);
    bus_xfer(64'h0000_0000_8000_0000);
    chk("t2_lbu_data", out_data, 64'h0000_0000_0000_0080);
    tick();
    // LH at offset 4 picks bytes 5:4 = 0x9ABC, sign bit set
    accept(4'd2, 64'h0000_0000_8000_0004, 64'd0, 5'd3, 1'b1);
    bus_xfer(64'h0000_9ABC_0000_0000);
    chk("t2_lh_data", out_data, 64'hFFFF_FFFF_FFFF_9ABC);
    tick();

    // ---------------- 3: SH store lanes
    accept(4'd9, 64'h0000_0000_8000_0006, 64'h0000_0000_0000_1234, 5'd9, 1'b1);
    chk("t3_sh_req", bus_req_valid, 1);
    chk("t3_sh_wmask", {56'd0, bus_wmask}, 64'hC0);
    chk("t3_sh_wdata", bus_wdata, 64'h1234_0000_0000_0000);
    chk("t3_sh_wen", bus_wen, 1);
    chk("t3_sh_addr", bus_addr, 64'h0000_0000_8000_0000);
    bus_xfer(64'hFFFF_FFFF_FFFF_FFFF);
    chk("t3_sh_valid", out_valid, 1);
    chk("t3_sh_out_wen", out_wen, 0);
    chk("t3_sh_out_data", out_data, 0);
    tick();
    // SB at offset 5
    accept(4'd8, 64'h0000_0000_8000_0105, 64'h0000_0000_0000_00A5, 5'd9, 1'b1);
    chk("t3_sb_wmask", {56'd0, bus_wmask}, 64'h20);
    chk("t3_sb_wdata", bus_wdata, 64'h0000_A500_0000_0000);
    chk("t3_sb_addr", bus_addr, 64'h0000_0000_8000_0100);
    bus_xfer(64'd0);
    tick();

    // ---------------- 4: misaligned LW
    accept(4'd3, 64'h0000_0000_8000_0002, 64'd0, 5'd4, 1'b1);
    chk("t4_no_req", bus_req_valid, 0);
    chk("t4_valid", out_valid, 1);
    chk("t4_misalign", misalign, 1);
    chk("t4_out_wen", out_wen, 0);
    chk("t4_out_data", out_data, 0);
    tick();
    chk("t4_back_idle", in_ready, 1);

    // ---------------- 5: NONE pass-through with write-back stall
    out_ready = 1'b0;
    accept(4'd0, 64'h0000_0000_0000_002A, 64'd0, 5'd5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("t5_valid", out_valid, 1);
      chk("t5_data", out_data, 64'h2A);
      chk("t5_rd", {59'd0, out_rd}, 5);
      chk("t5_wen", out_wen, 1);
      chk("t5_misalign", misalign, 0);
      chk("t5_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    chk("t5_valid_hold", out_valid, 1);
    tick();
    chk("t5_released", out_valid, 0);
    chk("t5_in_ready_back", in_ready, 1);
    // Reserved op 14 behaves as NONE
    accept(4'd14, 64'h0000_0000_0000_0777, 64'd0, 5'd2, 1'b1);
    chk("t5_rsv_data", out_data, 64'h777);
    chk("t5_rsv_req", bus_req_valid, 0);
    tick();

    // ---------------- 6: LD with delayed grant and response
    accept(4'd4, 64'h0000_0000_8000_0010, 64'd0, 5'd6, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("t6_req", bus_req_valid, 1);
      chk("t6_addr", bus_addr, 64'h0000_0000_8000_0010);
      chk("t6_wen", bus_wen, 0);
      chk("t6_wmask", {56'd0, bus_wmask}, 0);
      tick();
    end
    bus_req_ready = 1'b1;
    tick();
    bus_req_ready = 1'b0;
    chk("t6_req_done", bus_req_valid, 0);
    for (int i = 0; i < 2; i++) begin
      chk("t6_wait", out_valid, 0);
      tick();
    end
    bus_rsp_valid = 1'b1;
    bus_rsp_rdata = 64'h0123_4567_89AB_CDEF;
    begin : b_wait_out
      int budget;
      budget = 0;
      tick();
      bus_rsp_valid = 1'b0;
      while (!out_valid && budget < 20) begin
        tick();
        budget++;
      end
      chk("t6_timeout", {63'd0, out_valid}, 1);
    end
    chk("t6_data", out_data, 64'h0123_4567_89AB_CDEF);
    chk("t6_out_wen", out_wen, 1);
    chk("t6_rd", {59'd0, out_rd}, 6);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
